// File: rtl/comb_case_bist_pkg.sv
// Shared types and constants for the combinational-case BIST engine.
package comb_case_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int              MISR_W_DEF    = 16;
    localparam logic [15:0]     MISR_POLY_DEF = 16'h002D;
    localparam int              N_OUT         = 3;

    function automatic int pat_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/comb_case_bist_misr.sv
// Galois-form multiple-input signature register compacting the case responses.
module misr_compactor #(
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h002D,
    parameter int                N_OUT     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [N_OUT-1:0]  din,
    output logic [MISR_W-1:0] sig
);

    logic [MISR_W-1:0] sig_q;
    logic [MISR_W-1:0] sig_d;

    always_comb begin
        sig_d = {sig_q[MISR_W-2:0], 1'b0}
              ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
              ^ MISR_W'(din);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (clr) begin
            sig_q <= '0;
        end else if (en) begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/comb_case_bist.sv
// BIST engine: walks every input pattern of a 6-in/3-out case and compacts
// the responses into a MISR signature checked against a golden value.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; outputs quiet
//   ST_RUN   | loading one pattern per edge, capture pipe filling
//   ST_DRAIN | all patterns loaded; pattern held at 0 while the pipe empties
//   ST_DONE  | signature frozen, pass valid; start re-runs
module comb_case_bist
    import comb_case_bist_pkg::*;
#(
    parameter int                N_IN      = 6,
    parameter int                MISR_W    = MISR_W_DEF,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_POLY_DEF,
    parameter int                LAT       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [MISR_W-1:0] golden,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic              e,
    output logic              f,
    input  logic              y1,
    input  logic              y2,
    input  logic              y3,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic [N_IN-1:0]   pat_idx
);

    localparam int              PAT_CNT  = pat_count(N_IN);
    localparam logic [N_IN-1:0] LAST_PAT = N_IN'(PAT_CNT - 1);

    state_t            state_q;
    logic [N_IN-1:0]   pat_q;
    logic [N_IN-1:0]   pat_nxt;
    logic [LAT-1:0]    vld_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              start_ok;
    logic              misr_clr;
    logic              misr_en;
    logic [MISR_W-1:0] sig;

    assign pat_nxt  = pat_q + 1'b1;
    assign start_ok = start && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
    assign misr_clr = start_ok;
    // A response is absorbed when its valid bit leaves the pipe; abort blocks it.
    assign misr_en  = vld_q[LAT-1] && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            vld_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else if (abort) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            vld_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        pat_q   <= '0;
                        vld_q   <= LAT'({vld_q, 1'b1});
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    pat_q <= pat_nxt;
                    vld_q <= LAT'({vld_q, 1'b1});
                    if (pat_nxt == LAST_PAT) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    pat_q <= '0;
                    vld_q <= LAT'({vld_q, 1'b0});
                    // Pipe already empty: the last capture landed on the previous edge.
                    if (vld_q == '0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (sig == golden);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    pat_q   <= '0;
                    vld_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    misr_compactor #(
        .MISR_W    (MISR_W),
        .MISR_POLY (MISR_POLY),
        .N_OUT     (N_OUT)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (misr_en),
        .din   ({y1, y2, y3}),
        .sig   (sig)
    );

    assign {a, b, c, d, e, f} = pat_q;
    assign pat_idx   = pat_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig;

endmodule

// File: tb/tb_comb_case_bist.sv
// Self-checking bench: behavioural case model drives y, a software MISR over
// all patterns predicts each run; a monitor checks every completed run.
module tb_comb_case_bist;

    localparam logic [15:0] POLY    = 16'h002D;
    localparam int          EXP_LAT = 64 + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] golden = 16'h0000;
    logic        a, b, c, d, e, f;
    logic        y1, y2, y3;
    logic        busy, done, pass;
    logic [15:0] signature;
    logic [5:0]  pat_idx;

    logic        zm = 1'b1;
    logic [5:0]  m1 = 6'd0;
    logic [5:0]  m2 = 6'd0;
    int          fp = -1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    comb_case_bist dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .golden    (golden),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature),
        .pat_idx   (pat_idx)
    );

    function automatic logic [2:0] case_y(input logic [5:0] p, input logic z,
                                          input logic [5:0] k1, input logic [5:0] k2,
                                          input int fpat);
        logic o1, o2, o3;
        if (z) return 3'b000;
        o1 = (^(p & k1)) | (p[5] & p[0]);
        o2 = (int'(p) + int'(k2)) > 63;
        o3 = p[2] ^ (p[4] & p[3]);
        if (int'(p) == fpat) o1 = ~o1;
        return {o1, o2, o3};
    endfunction

    assign {y1, y2, y3} = case_y({a, b, c, d, e, f}, zm, m1, m2, fp);

    // Signature after absorbing the responses of patterns 0..n-1.
    function automatic logic [15:0] ref_sig(input int n);
        logic [15:0] s;
        s = 16'h0000;
        for (int j = 0; j < n; j++) begin
            s = (s << 1) ^ (s[15] ? POLY : 16'h0000) ^ 16'(case_y(6'(j), zm, m1, m2, fp));
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    task automatic expect_run(input logic [15:0] g);
        exp_t it;
        it.sig  = ref_sig(64);
        it.pass = (it.sig == g);
        it.lat  = EXP_LAT;
        golden  = g;
        sb.push_back(it);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (sb.size() != 0) begin
            chk("run_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic wait_pat(input logic [5:0] p);
        int i;
        i = 0;
        while (pat_idx != p && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (pat_idx != p) chk("wait_pat_timeout", 32'(pat_idx), 32'(p));
    endtask

    // Monitor: walks, latency, and signature/pass of every completed run.
    int cyc = 0;
    int busy_cyc = 0;
    int exp_pat = 64;
    int walk_err = 0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        exp_t it;
        if (!rst_n) begin
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                busy_cyc = cyc;
                exp_pat  = 0;
                walk_err = 0;
            end
            if (busy && exp_pat < 64) begin
                if (pat_idx != exp_pat[5:0] || {a, b, c, d, e, f} != exp_pat[5:0]) walk_err++;
                exp_pat++;
            end
            if (done && !prev_done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(done), 0);
                end else begin
                    it = sb.pop_front();
                    chk("run_signature", 32'(signature), 32'(it.sig));
                    chk("run_pass", 32'(pass), 32'(it.pass));
                    chk("run_latency", cyc - busy_cyc, it.lat);
                    chk("run_walk", {16'(walk_err), 16'(exp_pat)}, {16'd0, 16'd64});
                    chk("run_busy_low", 32'(busy), 0);
                end
            end
            prev_busy = busy;
            prev_done = done;
        end
        cyc++;
    end

    initial begin
        logic [15:0] g;

        #12;
        chk("reset_outputs", {1'b0, a, b, c, d, e, f, busy, done, pass, pat_idx, signature}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a run
        zm = 1'b0;
        m1 = 6'($urandom);
        m2 = 6'($urandom);
        fp = -1;
        pulse_start();
        chk("busy_rise", 32'(busy), 1);
        repeat (10 + $urandom_range(0, 20)) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset", {1'b0, a, b, c, d, e, f, busy, done, pass, pat_idx, signature}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero responses, matching and mismatching golden
        zm = 1'b1;
        expect_run(16'h0000);
        pulse_start();
        chk("busy_rise_zero", 32'(busy), 1);
        wait_done();
        expect_run(16'h0001);
        pulse_start();
        wait_done();

        // Behavioural case, correct golden, stray start mid-run
        zm = 1'b0;
        m1 = 6'($urandom);
        m2 = 6'($urandom);
        expect_run(ref_sig(64));
        pulse_start();
        wait_pat(6'd10);
        pulse_start();
        wait_done();

        // Single flipped response at pattern 37
        g  = ref_sig(64);
        fp = 37;
        expect_run(g);
        pulse_start();
        wait_done();
        chk("flip_pass_low", 32'(pass), 0);

        // Abort at pattern 20, then rerun
        fp = -1;
        pulse_start();
        wait_pat(6'd20);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pattern", {a, b, c, d, e, f, pat_idx}, 0);
        chk("abort_done", {done, pass}, 0);
        chk("abort_sig_hold", 32'(signature), 32'(ref_sig(20)));
        repeat (80) @(negedge clk);
        chk("abort_no_done", {busy, done}, 0);
        expect_run(ref_sig(64));
        pulse_start();
        wait_done();

        // DONE holds, then restart from DONE
        repeat (20) @(negedge clk);
        chk("done_hold", {done, pass}, 2'b11);
        chk("done_sig_frozen", 32'(signature), 32'(ref_sig(64)));
        m1 = 6'($urandom);
        m2 = 6'($urandom);
        expect_run(16'($urandom));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_done_clear", {done, pass, busy}, 3'b001);
        chk("restart_sig_clear", 32'(signature), 0);
        wait_done();

        // Abort from DONE, then simultaneous start and abort
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_from_done", {done, pass, busy}, 0);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_abort_idle", {busy, done, pat_idx}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/comb_case_bist.md
Name: comb_case_bist

Overview:
- Sequential built-in self-test engine for the team's 6-input/3-output combinational synthesis cases.
- It is the driving end of the case interface. It generates every input pattern on a..f exhaustively and samples y1..y3.
- Responses are compacted into a MISR signature, which is compared against a golden value.
- It sits beside a synthesized case netlist so the netlist can be checked in simulation or on silicon without an external vector file.

Parameters:
- N_IN, 6: pattern width; pattern count is 2**N_IN.
- MISR_W, 16: signature width.
- MISR_POLY, 16'h002D: feedback taps, x^16+x^5+x^3+x^2+1.
- LAT, 1: edges from a pattern register update to the edge at which its response is sampled (1..4).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a test; level-sampled in IDLE or DONE
- abort  in  1  synchronous abort; returns to IDLE
- golden  in  MISR_W  expected signature
- a,b,c,d,e,f  out  1 each  pattern to the case; a = MSB, f = LSB
- y1,y2,y3  in  1 each  case responses
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- pass  out  1  signature == golden; valid while done
- signature  out  MISR_W  current MISR contents
- pat_idx  out  N_IN  pattern currently driven

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: a..f=0, busy=0, done=0, pass=0, signature=0, pat_idx=0, state=IDLE, capture-valid pipe cleared.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, on start:
  - MISR cleared to 0.
  - {a..f} <= 0, pat_idx <= 0.
  - state <= RUN.
- RUN: each edge, {a..f} <= pat_idx+1.
  - The edge that loads pattern 2**N_IN-1 also sets state <= DRAIN.
  - No wrap: pattern count is exact.
- Capture pipe: a LAT-deep valid shift register.
  - A bit enters with each pattern load.
  - When the bit exits, the MISR updates with y = {y1,y2,y3}.
- Capture timing: pattern j loaded at edge k+j is captured at edge k+j+LAT, where k is the start-sampling edge.
- DRAIN: {a..f} <= 0. Captures continue until the pipe is empty, then state <= DONE.
- DONE:
  - Reached at edge k+2**N_IN+LAT; for defaults, 65 edges after start.
  - done=1.
  - pass = (signature == golden), registered on DONE entry.
  - Signature frozen.
- DONE, on start: identical to IDLE start. done and pass clear on that edge.
- DONE with start low: held indefinitely.
- start while in RUN or DRAIN: ignored.
- MISR update, Galois left shift: sig <= {sig[MISR_W-2:0],1'b0} ^ (sig[MISR_W-1] ? MISR_POLY : 0) ^ zero-extended y. y1 is bit 2, y3 is bit 0.
- abort: priority over start and all transitions, in any state.
  - Next edge: state=IDLE, a..f=0, pipe cleared, busy=0, done=0, pass=0.
  - signature keeps its last value until the next start clears it.
- Asynchronous reset mid-operation: immediate return to reset values. No partial done pulse.
- Simultaneous start and abort: abort wins, and the block stays IDLE.

Decomposition:
- Shared package comb_case_bist_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default MISR_POLY / MISR_W constants
  - pattern-count function 2**N_IN
- One natural sub-module, misr_compactor: clk, rst_n, clr, en, din[N_OUT], sig[MISR_W]. It holds the polynomial update only.
- FSM, pattern counter and capture pipe stay in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → all outputs 0 asynchronously, before the next clk edge.
- Tie y=3'b000, golden=16'h0000, pulse start:
  - busy rises next edge.
  - a..f walks 0..63 one per edge, a = MSB.
  - done rises exactly 65 edges after start.
  - signature=16'h0000, pass=1.
- Same stimulus with golden=16'h0001 → done at the same edge, pass=0.
- y from a behavioural model of the case logic, golden from a software MISR model over 64 patterns → pass=1.
- Repeat with y1 inverted for pattern 37 only → pass=0.
- abort asserted in RUN while pat_idx=20:
  - Next edge: IDLE, busy=0, a..f=0, done never asserted.
  - A subsequent start reproduces the uninterrupted signature.
- start during DONE → done=0 on that edge and a second run completes.
- Also assert start during RUN at pat_idx=10 → ignored, total pattern count still 64.
